// File: rtl/alarm_clock_pkg.sv
// Shared alarm-clock definitions: controller state encoding and default keypad/timeout settings.
// Also used by the keyreg and lcd_driver_4 blocks.
package alarm_clock_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  localparam logic [3:0] NOKEY_DEFAULT        = 4'd10;
  localparam int         TIMEOUT_SECS_DEFAULT = 10;

  // States in which the inactivity timer is allowed to run.
  function automatic logic timer_running(input state_t s);
    return (s == KEY_WAITED) || (s == KEY_ENTRY);
  endfunction

endpackage

// File: rtl/alarm_fsm_timer.sv
// Saturating seconds counter for abandoning key entry after TIMEOUT_SECS idle seconds.
// Only instantiated when ALARM_FSM_TIMEOUT_EN is defined.
module alarm_fsm_timer #(
  parameter int TIMEOUT_SECS = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_SECS + 1);

  logic [CW-1:0] count_reg;

  assign timeout = (count_reg == CW'(TIMEOUT_SECS));

  // Clear has priority over tick; the count holds once it reaches the limit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (tick && !timeout) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_fsm.sv
// Alarm-clock controller: Moore FSM sequencing display selection, key shifting and load strobes.
// Define ALARM_FSM_TIMEOUT_EN to abandon key entry after TIMEOUT_SECS seconds without a key.
module alarm_fsm
  import alarm_clock_pkg::*;
#(
  parameter int         TIMEOUT_SECS = TIMEOUT_SECS_DEFAULT,
  parameter logic [3:0] NOKEY        = NOKEY_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       show_a,
  output logic       show_current_time,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       shift
);

  state_t state_reg;
  state_t state_next;
  logic   timeout;
  logic   key_pressed;

  assign key_pressed = (key != NOKEY);

`ifdef ALARM_FSM_TIMEOUT_EN
  alarm_fsm_timer #(
    .TIMEOUT_SECS(TIMEOUT_SECS)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!timer_running(state_reg)),
    .tick   (one_second),
    .timeout(timeout)
  );
`else
  logic unused_one_second;
  assign unused_one_second = one_second;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= SHOW_TIME;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SHOW_TIME: begin
        if (alarm_button) begin
          state_next = SHOW_ALARM;
        end else if (key_pressed) begin
          state_next = KEY_STORED;
        end
      end
      KEY_STORED: begin
        state_next = KEY_WAITED;
      end
      KEY_WAITED: begin
        // Wait for release so a held key is shifted only once.
        if (!key_pressed) begin
          state_next = KEY_ENTRY;
        end else if (timeout) begin
          state_next = SHOW_TIME;
        end
      end
      KEY_ENTRY: begin
        if (alarm_button) begin
          state_next = SET_ALARM_TIME;
        end else if (time_button) begin
          state_next = SET_CURRENT_TIME;
        end else if (key_pressed) begin
          state_next = KEY_STORED;
        end else if (timeout) begin
          state_next = SHOW_TIME;
        end
      end
      SHOW_ALARM: begin
        if (!alarm_button) begin
          state_next = SHOW_TIME;
        end
      end
      SET_ALARM_TIME:   state_next = SHOW_TIME;
      SET_CURRENT_TIME: state_next = SHOW_TIME;
      default:          state_next = SHOW_TIME;
    endcase
  end

  always_comb begin
    show_a            = 1'b0;
    show_current_time = 1'b0;
    load_new_a        = 1'b0;
    load_new_c        = 1'b0;
    shift             = 1'b0;
    case (state_reg)
      KEY_STORED: begin
        shift             = 1'b1;
        show_current_time = 1'b1;
      end
      KEY_WAITED:       show_current_time = 1'b1;
      KEY_ENTRY:        show_current_time = 1'b1;
      SHOW_ALARM:       show_a = 1'b1;
      SET_ALARM_TIME:   load_new_a = 1'b1;
      SET_CURRENT_TIME: load_new_c = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alarm_fsm.sv
// Scoreboard bench for alarm_fsm: directed scenarios plus random stimulus checked
// against a mode-based reference model of the controller rules.
module tb_alarm_fsm;

  localparam int         T_SECS = 10;
  localparam logic [3:0] NK     = 4'd10;

  logic       clock;
  logic       reset;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       show_a;
  logic       show_current_time;
  logic       load_new_a;
  logic       load_new_c;
  logic       shift;

  alarm_fsm dut (
    .clock            (clock),
    .reset            (reset),
    .one_second       (one_second),
    .key              (key),
    .alarm_button     (alarm_button),
    .time_button      (time_button),
    .show_a           (show_a),
    .show_current_time(show_current_time),
    .load_new_a       (load_new_a),
    .load_new_c       (load_new_c),
    .shift            (shift)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  // Expected output vector: {show_a, show_current_time, load_new_a, load_new_c, shift}
  logic [4:0] exp_q[$];
  int         cyc_q[$];

  // Reference model: the controller's behaviour expressed as user-visible modes.
  typedef enum int {M_IDLE, M_JUST_PRESSED, M_HOLDING, M_ENTERING, M_VIEW_ALARM, M_COMMIT_A, M_COMMIT_C} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_secs = 0;
`ifdef ALARM_FSM_TIMEOUT_EN
  bit    m_timeout_en = 1'b1;
`else
  bit    m_timeout_en = 1'b0;
`endif

  function automatic logic [4:0] mode_outputs(input mode_t m);
    case (m)
      M_JUST_PRESSED: return 5'b01001;
      M_HOLDING:      return 5'b01000;
      M_ENTERING:     return 5'b01000;
      M_VIEW_ALARM:   return 5'b10000;
      M_COMMIT_A:     return 5'b00100;
      M_COMMIT_C:     return 5'b00010;
      default:        return 5'b00000;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic [3:0] k, input logic ab,
                            input logic tb_, input logic os);
    bit    pressed = (k != NK);
    bit    expired = m_timeout_en && (m_secs == T_SECS);
    mode_t nm = m_mode;
    if (!r) begin
      m_mode = M_IDLE;
      m_secs = 0;
      return;
    end
    case (m_mode)
      M_IDLE:         nm = ab ? M_VIEW_ALARM : (pressed ? M_JUST_PRESSED : M_IDLE);
      M_JUST_PRESSED: nm = M_HOLDING;
      M_HOLDING:      nm = !pressed ? M_ENTERING : (expired ? M_IDLE : M_HOLDING);
      M_ENTERING:     nm = ab ? M_COMMIT_A : tb_ ? M_COMMIT_C : pressed ? M_JUST_PRESSED :
                           expired ? M_IDLE : M_ENTERING;
      M_VIEW_ALARM:   nm = ab ? M_VIEW_ALARM : M_IDLE;
      default:        nm = M_IDLE;
    endcase
    // Seconds accumulate only while waiting on the keypad, capped at the limit.
    if (m_mode == M_HOLDING || m_mode == M_ENTERING) begin
      if (os && m_secs < T_SECS) m_secs++;
    end else begin
      m_secs = 0;
    end
    m_mode = nm;
  endtask

  task automatic cyc(input logic r, input logic [3:0] k, input logic ab,
                     input logic tb_, input logic os);
    reset = r; key = k; alarm_button = ab; time_button = tb_; one_second = os;
    @(posedge clock);
    cycle++;
    model_step(r, k, ab, tb_, os);
    exp_q.push_back(mode_outputs(m_mode));
    cyc_q.push_back(cycle);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, NK, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input logic [3:0] k);
    cyc(1'b1, k, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, NK, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, NK, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert reset mid-cycle and confirm outputs drop before any clock edge.
  task automatic async_reset_check(input string tag);
    logic [4:0] act;
    reset = 1'b0;
    #1;
    act = {show_a, show_current_time, load_new_a, load_new_c, shift};
    total++;
    if (act !== 5'b0) begin
      bad++;
      $display("FAIL %s: outputs=%b required=00000", tag, act);
    end
    cyc(1'b0, NK, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, NK, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle, so pop one expectation per clock.
  initial begin
    logic [4:0] e, a;
    int c;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        a = {show_a, show_current_time, load_new_a, load_new_c, shift};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs cycle %0d: actual=%b required=%b", c, a, e);
        end
        total++;
        if ($countones({show_a, show_current_time}) > 1 ||
            $countones({load_new_a, load_new_c, shift}) > 1) begin
          bad++;
          $display("FAIL exclusivity cycle %0d: actual=%b required=at most one per group", c, a);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; key = NK; alarm_button = 1'b0; time_button = 1'b0; one_second = 1'b0;
    @(negedge clock);
    cyc(1'b0, NK, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, NK, 1'b0, 1'b0, 1'b0);
    // Idle after reset release
    idle(8);
    // Held key shifts once
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Four digits then alarm commit
    press(4'd2); press(4'd1); press(4'd3); press(4'd4);
    cyc(1'b1, NK, 1'b1, 1'b0, 1'b0);
    idle(3);
    // Four digits then time commit
    press(4'd2); press(4'd1); press(4'd3); press(4'd4);
    cyc(1'b1, NK, 1'b0, 1'b1, 1'b0);
    idle(3);
    // Alarm view held 20 cycles
    for (int i = 0; i < 20; i++) cyc(1'b1, NK, 1'b1, 1'b0, 1'b0);
    idle(3);
    // Timeout: one key then ten seconds of silence
    press(4'd7);
    for (int i = 0; i < T_SECS; i++) begin
      cyc(1'b1, NK, 1'b0, 1'b0, 1'b1);
      idle(2);
    end
    idle(3);
    // Nine seconds, then a key restarts the count
    press(4'd5);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, NK, 1'b0, 1'b0, 1'b1);
      idle(1);
    end
    cyc(1'b1, 4'd6, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, NK, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, NK, 1'b0, 1'b0, 1'b1);
    idle(2);
    // Reset during key entry and during the alarm load strobe
    press(4'd8);
    async_reset_check("reset in entry");
    idle(2);
    press(4'd9);
    cyc(1'b1, NK, 1'b1, 1'b0, 1'b0);
    async_reset_check("reset in load");
    idle(3);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] k;
      k = ($urandom_range(0, 9) < 7) ? NK : 4'($urandom_range(0, 9));
      cyc(($urandom_range(0, 199) != 0),
          k,
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 3) == 0));
    end
    idle(2);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
    #3;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
